// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the display scan controller.
//   scan_state_t     : scan FSM encoding (IDLE / BLANK / SHOW)
//   DIGITS           : number of multiplexed digits
//   ANODE_OFF        : all anodes released (common-anode, active-low)
//   digit_suppressed : leading-zero test for one digit of the latched value
//   max_int          : integer max, used to size the scan timer
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam int         DIGITS    = 4;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // A digit is dark when it and every nibble above it are zero. Digit 0
    // always lights so a zero value still shows "0".
    function automatic logic digit_suppressed(input logic [15:0] v,
                                              input logic [1:0]  d,
                                              input logic        lz);
        logic all_zero;
        case (d)
            2'd0:    all_zero = 1'b0;
            2'd1:    all_zero = (v[15:4] == 12'h000);
            2'd2:    all_zero = (v[15:8] == 8'h00);
            default: all_zero = (v[15:12] == 4'h0);
        endcase
        return lz && all_zero;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Down-counter shared by the BLANK and SHOW phases.
//   clk, reset : clock, async active-high reset
//   load       : reload the count with load_val (asserted on every state change)
//   load_val   : phase length minus one (0 when returning to idle)
//   tc         : terminal count, high while the count sits at zero
module display_scan_controller_scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Walks dig_sel 0..3 with a blank gap before each digit, drives the
// active-low anodes, and double-buffers the displayed value so it only
// changes on frame boundaries.
//   clk, reset    : clock, async active-high reset
//   enable        : scan enable; low parks the scanner idle with anodes off
//   value         : new display value, captured on value_load
//   value_load    : single-cycle load strobe
//   lz_en         : leading-zero suppression enable
//   value_latched : value currently being displayed (to nibble selector)
//   dig_sel       : current digit index (0 = bits 3:0)
//   anode_n       : active-low anode enables, bit i = digit i
//   frame_done    : one-clock pulse in the first BLANK cycle after digit 3
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        value_load,
    input  logic        lz_en,
    output logic [15:0] value_latched,
    output logic [1:0]  dig_sel,
    output logic [3:0]  anode_n,
    output logic        frame_done
);

    localparam int CNT_W = max_int(1, $clog2(max_int(ON_CYCLES, BLANK_CYCLES)));
    localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t state_q, state_d;
    logic [1:0]  dig_q, dig_d;
    logic [3:0]  anode_q, anode_d;
    logic        fd_q, fd_d;
    logic [15:0] latched_q, pend_q;
    logic        pend_flag_q;
    logic        boundary;
    logic        tmr_load, tmr_tc;
    logic [CNT_W-1:0] tmr_val;

    display_scan_controller_scan_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        fd_d     = 1'b0;
        boundary = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            dig_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    dig_d   = 2'd0;
                end
                ST_BLANK: begin
                    if (tmr_tc)
                        state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (tmr_tc) begin
                        state_d = ST_BLANK;
                        if (dig_q == 2'(DIGITS - 1)) begin
                            dig_d    = 2'd0;
                            fd_d     = 1'b1;
                            boundary = 1'b1;
                        end else begin
                            dig_d = dig_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dig_d   = 2'd0;
                end
            endcase
        end

        // Anodes are computed from the next state so they switch in the
        // same cycle the state register does.
        anode_d = ANODE_OFF;
        if (state_d == ST_SHOW && !digit_suppressed(latched_q, dig_d, lz_en))
            anode_d[dig_d] = 1'b0;

        // Any state change restarts the timer; idle parks it at zero.
        tmr_load = (state_d != state_q);
        case (state_d)
            ST_SHOW:  tmr_val = ON_LOAD;
            ST_BLANK: tmr_val = BLANK_LOAD;
            default:  tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dig_q   <= 2'd0;
            anode_q <= ANODE_OFF;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            anode_q <= anode_d;
            fd_q    <= fd_d;
        end
    end

    // Double buffer: nothing is being scanned in idle, so updates land at
    // once; while scanning they wait for the digit-3 -> digit-0 boundary.
    // A load coinciding with the boundary goes straight to the display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latched_q   <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_flag_q <= 1'b0;
        end else if (state_q == ST_IDLE || boundary) begin
            if (value_load) begin
                latched_q   <= value;
                pend_flag_q <= 1'b0;
            end else if (pend_flag_q) begin
                latched_q   <= pend_q;
                pend_flag_q <= 1'b0;
            end
        end else if (value_load) begin
            pend_q      <= value;
            pend_flag_q <= 1'b1;
        end
    end

    assign value_latched = latched_q;
    assign dig_sel       = dig_q;
    assign anode_n       = anode_q;
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

    localparam int ON    = 5;
    localparam int BLK   = 2;
    localparam int SLOT  = ON + BLK;
    localparam int FRAME = 4 * SLOT;

    logic        clk, reset, enable, value_load, lz_en;
    logic [15:0] value, value_latched;
    logic [1:0]  dig_sel;
    logic [3:0]  anode_n;
    logic        frame_done;

    display_scan_controller #(.ON_CYCLES(ON), .BLANK_CYCLES(BLK)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .value         (value),
        .value_load    (value_load),
        .lz_en         (lz_en),
        .value_latched (value_latched),
        .dig_sel       (dig_sel),
        .anode_n       (anode_n),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dig;
        logic [3:0]  an;
        logic        fd;
        logic [15:0] lat;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: position m_t counts clocks since the frame's first
    // BLANK cycle; digit and phase come from plain division of that position.
    bit          m_run;
    int          m_t;
    logic [15:0] m_lat, m_pend;
    bit          m_flag;
    exp_t        m_out;

    function automatic void m_outputs(input bit fd);
        int p, d, r;
        m_out.fd  = fd;
        m_out.lat = m_lat;
        m_out.dig = 2'd0;
        m_out.an  = 4'b1111;
        if (m_run) begin
            p = m_t % FRAME;
            d = p / SLOT;
            r = p % SLOT;
            m_out.dig = 2'(d);
            if (r >= BLK && !(lz_en && d > 0 && (m_lat >> (4 * d)) == 16'h0))
                m_out.an[d] = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        m_run = 0; m_t = 0; m_lat = 16'h0; m_pend = 16'h0; m_flag = 0;
        m_outputs(1'b0);
    endfunction

    function automatic void m_step();
        bit was_idle, bnd;
        was_idle = !m_run;
        bnd      = m_run && enable && (m_t % FRAME == FRAME - 1);
        if (was_idle || bnd) begin
            if (value_load) begin
                m_lat = value; m_flag = 0;
            end else if (m_flag) begin
                m_lat = m_pend; m_flag = 0;
            end
        end else if (value_load) begin
            m_pend = value; m_flag = 1;
        end
        if (!enable)       m_run = 0;
        else if (was_idle) begin m_run = 1; m_t = 0; end
        else               m_t++;
        m_outputs(bnd);
    endfunction

    // One clock: model follows the DUT edge, expectation queued, inputs may
    // then change at posedge+1.
    task automatic tick();
        @(posedge clk);
        if (reset) m_reset();
        else       m_step();
        expq.push_back(m_out);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (!(m_run && (m_t % FRAME) == p)) begin
            tick();
            n++;
            if (n > 200) begin
                n_vec++; n_err++;
                $display("FAIL wait_pos(%0d): position not reached within 200 cycles", p);
                return;
            end
        end
    endtask

    task automatic load(input logic [15:0] v);
        value = v; value_load = 1'b1;
        tick();
        value_load = 1'b0;
    endtask

    // Monitor: every output is valid every cycle; compare at the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                n_vec++;
                if (dig_sel !== e.dig || anode_n !== e.an ||
                    frame_done !== e.fd || value_latched !== e.lat) begin
                    n_err++;
                    $display("FAIL scan @%0t: got dig=%0d an=%b fd=%b lat=%h, expected dig=%0d an=%b fd=%b lat=%h",
                             $time, dig_sel, anode_n, frame_done, value_latched,
                             e.dig, e.an, e.fd, e.lat);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; value = 16'h0; value_load = 1'b0; lz_en = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Free-running scan from idle: two full frames.
        enable = 1'b1;
        repeat (60) tick();

        // Load while idle lands next cycle.
        enable = 1'b0;
        repeat (2) tick();
        load(16'h1234);
        repeat (2) tick();

        // Mid-frame loads are held until the boundary, last one wins.
        enable = 1'b1;
        wait_pos(11); load(16'hABCD);
        wait_pos(17); load(16'hBEEF);
        repeat (15) tick();

        // Load exactly on the boundary bypasses pending.
        wait_pos(FRAME - 1); load(16'h5555);
        repeat (FRAME + 4) tick();

        // Leading-zero suppression.
        lz_en = 1'b1;
        wait_pos(5); load(16'h0070);
        repeat (2 * FRAME) tick();
        wait_pos(5); load(16'h0000);
        repeat (2 * FRAME) tick();
        lz_en = 1'b0;

        // Drop enable during digit 2 SHOW, then restart.
        wait_pos(17); enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (FRAME + 6) tick();

        // Randomised traffic.
        repeat (800) begin
            enable     = ($urandom_range(0, 39) != 0);
            value_load = ($urandom_range(0, 11) == 0);
            value      = 16'($urandom >> (4 * $urandom_range(0, 4)));
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            tick();
        end
        value_load = 1'b0;

        // Async reset mid-SHOW with a value still pending.
        enable = 1'b1;
        wait_pos(3); load(16'h9999);
        wait_pos(10);
        @(posedge clk);
        #2 reset = 1'b1;
        m_reset();
        expq.push_back(m_out);
        repeat (2) tick();
        reset = 1'b0;
        repeat (FRAME + 6) tick();

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
